// File: rtl/fifo_rd_arb.sv
// Two-requester read arbiter/sequencer for the pixel FIFO: round-robin bursts of up to BURST words.
// Define FIFO_ARB_PRIO_EN for strict priority (req0 always wins a tie) instead of round-robin.
module fifo_rd_arb #(
    parameter int DW    = 10,
    parameter int BURST = 4
) (
    input  logic          Pclk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    output logic [1:0]    gnt,
    output logic [DW-1:0] dout,
    output logic          dvalid0,
    output logic          dvalid1,
    output logic          busy
);

    // state | meaning
    // IDLE  | no grant; pick an owner when data and a request are present
    // READ  | issue one read if the FIFO is not empty, else end the burst
    // WAIT  | read gap so the registered empty flag settles; decide burst end
    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;

    localparam logic [7:0] BURST_C = 8'(BURST);

    state_t        state_q;
    logic [1:0]    gnt_q;
    logic [7:0]    cnt_q;
    logic          last_q;
    logic          owner_q;
    logic          owner_d;
    logic          owner_req;
    logic          rd_dly_q;
    logic          tag_dly_q;
    logic [DW-1:0] dout_q;
    logic          dv0_q;
    logic          dv1_q;

    always_comb begin
        owner_d = 1'b0;
`ifdef FIFO_ARB_PRIO_EN
        owner_d = req1 & ~req0;
`else
        // last_q holds the previous owner, so a tie goes to the other one
        owner_d = req1 & (~req0 | ~last_q);
`endif
    end

    assign owner_req = owner_q ? req1 : req0;

    always_ff @(posedge Pclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            cnt_q   <= 8'd0;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty && (req0 || req1)) begin
                        owner_q <= owner_d;
                        gnt_q   <= owner_d ? 2'b10 : 2'b01;
                        cnt_q   <= 8'd0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (!fifo_empty) begin
                        cnt_q   <= cnt_q + 8'd1;
                        state_q <= WAIT;
                    end else begin
                        gnt_q   <= 2'b00;
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_q == BURST_C || !owner_req || fifo_empty) begin
                        gnt_q   <= 2'b00;
                        cnt_q   <= 8'd0;
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end else begin
                        state_q <= READ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The read strobe depends on this cycle's empty flag, so it cannot be registered.
    assign fifo_rd = (state_q == READ) && !fifo_empty;

    always_ff @(posedge Pclk or negedge rst) begin
        if (!rst) begin
            rd_dly_q  <= 1'b0;
            tag_dly_q <= 1'b0;
            dout_q    <= '0;
            dv0_q     <= 1'b0;
            dv1_q     <= 1'b0;
        end else begin
            rd_dly_q  <= fifo_rd;
            tag_dly_q <= owner_q;
            if (rd_dly_q) begin
                dout_q <= fifo_data;
            end
            dv0_q <= rd_dly_q & ~tag_dly_q;
            dv1_q <= rd_dly_q & tag_dly_q;
        end
    end

    assign gnt     = gnt_q;
    assign dout    = dout_q;
    assign dvalid0 = dv0_q;
    assign dvalid1 = dv1_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Scoreboard bench for fifo_rd_arb with a behavioural registered-output FIFO (BURST=4).
module tb_fifo_rd_arb;
    localparam int DW = 10;

    logic          Pclk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd;
    logic [1:0]    gnt;
    logic [DW-1:0] dout;
    logic          dvalid0, dvalid1;
    logic          busy;

    fifo_rd_arb #(.DW(DW), .BURST(4)) dut (
        .Pclk(Pclk), .rst(rst), .req0(req0), .req1(req1),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd(fifo_rd),
        .gnt(gnt), .dout(dout), .dvalid0(dvalid0), .dvalid1(dvalid1), .busy(busy)
    );

    always #5 Pclk = ~Pclk;

    typedef struct {
        bit            who;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] fq[$];
    int            n_pass  = 0;
    int            n_total = 0;
    bit            rd_prev = 1'b0;

    task automatic chk(input string nm, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, want);
    endtask

    // FIFO model: registered data_out and registered empty flag
    always @(posedge Pclk) begin
        if (fifo_rd && fq.size() > 0) fifo_data <= fq.pop_front();
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: pops the scoreboard whenever a dvalid is presented
    always @(negedge Pclk) begin
        exp_t e;
        if (fifo_rd) begin
            chk("rd_while_empty", int'(fifo_empty), 0);
            chk("rd_spacing", int'(rd_prev), 0);
        end
        rd_prev = fifo_rd;
        if (dvalid0 || dvalid1) begin
            chk("dvalid_onehot", int'(dvalid0 && dvalid1), 0);
            chk("dvalid_vs_gnt", int'((dvalid1 && gnt == 2'b01) || (dvalid0 && gnt == 2'b10)), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_dvalid", {dvalid1, dvalid0, 6'd0, 14'(dout)}, 0);
            end else begin
                e = exp_q.pop_front();
                chk("dvalid_consumer", int'(dvalid1), int'(e.who));
                chk("dout_value", int'(dout), int'(e.data));
            end
        end
    end

    task automatic load(input int base, input int n, input int who);
        for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
        if (who >= 0) begin
            for (int i = 0; i < n; i++) exp_q.push_back('{who: who[0], data: DW'(base + i)});
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge Pclk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        req0 = 1'b0;
        req1 = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            @(negedge Pclk);
            n++;
        end
        chk("idle_after_test", int'(busy), 0);
        repeat (2) @(negedge Pclk);
    endtask

    initial begin
        logic [16:0] rd_v, dv_v, rd_e, dv_e;
        int          n;

        rst  = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (3) @(negedge Pclk);
        chk("reset_outputs", {fifo_rd, gnt, dvalid0, dvalid1, busy, 22'(dout)}, 0);
        rst = 1'b1;
        repeat (2) @(negedge Pclk);

        // Single requester: six words, bursts of four
        load(1, 6, 0);
        repeat (3) @(negedge Pclk);
        req0 = 1'b1;
        rd_v = '0;
        dv_v = '0;
        for (int j = 1; j <= 16; j++) begin
            @(negedge Pclk);
            rd_v[j] = fifo_rd;
            dv_v[j] = dvalid0;
            if (j == 1)  chk("first_gnt", int'(gnt), 1);
            if (j == 9)  chk("gap_gnt_idle", int'(gnt), 0);
            if (j == 10) chk("second_burst_gnt", int'(gnt), 1);
        end
        rd_e = '0;
        dv_e = '0;
        rd_e[1] = 1'b1; rd_e[3] = 1'b1; rd_e[5] = 1'b1; rd_e[7] = 1'b1; rd_e[10] = 1'b1; rd_e[12] = 1'b1;
        dv_e[3] = 1'b1; dv_e[5] = 1'b1; dv_e[7] = 1'b1; dv_e[9] = 1'b1; dv_e[12] = 1'b1; dv_e[14] = 1'b1;
        chk("single_rd_cycles", int'(rd_v), int'(rd_e));
        chk("single_dvalid_cycles", int'(dv_v), int'(dv_e));
        wait_done();

        // FIFO drains mid-burst: three words to req1
        load('h101, 3, 1);
        repeat (3) @(negedge Pclk);
        req1 = 1'b1;
        wait_done();

        // Both requesters held high, sixteen words
`ifdef FIFO_ARB_PRIO_EN
        load('h200, 16, 0);
`else
        load('h200, 4, 0);
        load('h204, 4, 1);
        load('h208, 4, 0);
        load('h20C, 4, 1);
`endif
        repeat (3) @(negedge Pclk);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_done();

        // req0 drops in the cycle after its second read
        load('h301, 2, 0);
        load('h303, 4, 1);
        repeat (3) @(negedge Pclk);
        req0 = 1'b1;
        req1 = 1'b1;
        repeat (4) @(negedge Pclk);
        req0 = 1'b0;
        @(negedge Pclk);
        chk("drop_gap_gnt", int'(gnt), 0);
        @(negedge Pclk);
        chk("drop_moves_to_req1", int'(gnt), 2);
        wait_done();

        // Reset mid-burst right after a read: in-flight word discarded
        load('h401, 4, -1);
        repeat (3) @(negedge Pclk);
        req1 = 1'b1;
        n = 0;
        while (!fifo_rd && n < 20) begin
            @(negedge Pclk);
            n++;
        end
        chk("reset_test_saw_read", int'(fifo_rd), 1);
        @(posedge Pclk);
        #1 rst = 1'b0;
        #1 chk("midburst_reset_outputs", {fifo_rd, gnt, dvalid0, dvalid1, busy, 22'(dout)}, 0);
        repeat (3) @(negedge Pclk);
        req0 = 1'b1;
        for (int i = 2; i <= 4; i++) exp_q.push_back('{who: 1'b0, data: DW'('h400 + i)});
        rst = 1'b1;
        @(negedge Pclk);
        chk("first_tie_after_reset", int'(gnt), 1);
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
